// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
// Module  : float_pkg
// Purpose : Shared definitions for the packed-float blocks: default field
//           widths and the bit offsets of the {sign, exponent, fraction}
//           fields inside a packed float word.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package float_pkg;

  localparam int E_BIT_DEF = 8;   // exponent width
  localparam int F_BIT_DEF = 23;  // stored fraction width (hidden 1 not stored)
  localparam int I_BIT_DEF = 32;  // signed integer width

  // Packed layout: fraction occupies the low bits, exponent above it, sign on top.
  function automatic int frac_lsb();
    return 0;
  endfunction

  function automatic int exp_lsb(input int f_bit);
    return f_bit;
  endfunction

  function automatic int sign_pos(input int e_bit, input int f_bit);
    return e_bit + f_bit;
  endfunction

  // Offsets for the default format.
  localparam int C_FRAC_LSB = 0;
  localparam int C_EXP_LSB  = F_BIT_DEF;
  localparam int C_SIGN_POS = E_BIT_DEF + F_BIT_DEF;

endpackage
`default_nettype wire

// File: rtl/lead_one_enc.sv
`default_nettype none
// ============================================================================
// Module  : lead_one_enc
// Purpose : Parameterised priority encoder. Returns the index of the most
//           significant set bit of data, and a flag when data is all zeros.
// Ports   : data [W-1:0] in  - word to scan
//           idx           out - index of the highest 1 (0 when data is zero)
//           zero          out - data == 0
// Revision: 1.0 - initial release
// ============================================================================
module lead_one_enc #(
  parameter int W = 32
) (
  input  logic [W-1:0]                          data,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0]  idx,
  output logic                                  zero
);

  localparam int c_iw = (W > 1) ? $clog2(W) : 1;

  // Ascending scan: the last hit is the highest set bit, which gives priority
  // to the MSB without a chained mux.
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        idx  = i[c_iw-1:0];
        zero = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_to_float.sv
`default_nettype none
// ============================================================================
// Module  : int_to_float
// Purpose : Three-stage pipelined signed-integer to packed-float converter
//           with truncating rounding and a global stall for backpressure.
//             S0: sign / magnitude   S1: leading-one detect   S2: normalise/pack
// Ports   : clk        in  - clock, rising edge
//           rst_n      in  - synchronous active-low reset
//           in_data    in  - two's-complement integer [I_bit-1:0]
//           in_valid   in  - in_data is valid
//           in_ready   out - converter accepts in_data this cycle
//           out_data   out - {s, e[E_bit-1:0], f[F_bit-1:0]}
//           out_valid  out - out_data is valid
//           out_ready  in  - downstream accepts out_data
// Revision: 1.0 - initial release
// ============================================================================
module int_to_float
  import float_pkg::*;
#(
  parameter int               E_bit = E_BIT_DEF,
  parameter int               F_bit = F_BIT_DEF,
  parameter int               I_bit = I_BIT_DEF,
  parameter logic [E_bit-1:0] E_ref = {1'b0, {(E_bit-1){1'b1}}},
  parameter logic [E_bit-1:0] E_max = {E_bit{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [I_bit-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [E_bit+F_bit:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int               c_pw    = (I_bit > 1) ? $clog2(I_bit) : 1;
  // Exponent sum is one bit wider than either operand so the overflow test
  // cannot wrap.
  localparam int               c_xw    = ((E_bit > c_pw) ? E_bit : c_pw) + 1;
  localparam int               c_ow    = sign_pos(E_bit, F_bit) + 1;
  localparam logic [E_bit-1:0] c_e_sat = E_max - {{(E_bit-1){1'b0}}, 1'b1};

  // Pipeline registers
  logic             r_v0, r_v1, r_v2;
  logic             r_s0, r_s1;
  logic [I_bit-1:0] r_mag0, r_mag1;
  logic [c_pw-1:0]  r_p;
  logic             r_zero1;
  logic [c_ow-1:0]  r_out;

  // Combinational
  logic             w_adv;
  logic             w_s0;
  logic [I_bit-1:0] w_mag0;
  logic [c_pw-1:0]  w_p;
  logic             w_zero;
  logic [c_pw-1:0]  w_shamt;
  logic [I_bit-1:0] w_norm;
  logic [F_bit-1:0] w_frac;
  logic [c_xw-1:0]  w_esum;
  logic             w_ovf;
  logic [c_ow-1:0]  w_pack;
  logic             w_unused_norm;

  // Whole pipeline advances together; depends only on v2 and out_ready.
  assign w_adv     = !r_v2 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v2;
  assign out_data  = r_out;

  // S0: magnitude as unsigned, so the most-negative input maps to 2^(I_bit-1).
  assign w_s0   = in_data[I_bit-1];
  assign w_mag0 = w_s0 ? -in_data : in_data;

  // S1: leading-one detect on the registered magnitude.
  lead_one_enc #(
    .W (I_bit)
  ) u_lead_one_enc (
    .data (r_mag0),
    .idx  (w_p),
    .zero (w_zero)
  );

  // S2: shift the leading one up to bit I_bit-1 (the hidden bit).
  assign w_shamt = c_pw'(I_bit - 1) - r_p;
  assign w_norm  = r_mag1 << w_shamt;

  // Hidden bit and anything below the fraction window are discarded.
  assign w_unused_norm = ^w_norm;

  generate
    if (I_bit - 1 >= F_bit) begin : g_frac_trunc
      assign w_frac = w_norm[I_bit-2 -: F_bit];
    end else begin : g_frac_pad
      assign w_frac = {w_norm[I_bit-2:0], {(F_bit-I_bit+1){1'b0}}};
    end
  endgenerate

  assign w_esum = c_xw'(E_ref) + c_xw'(r_p);
  assign w_ovf  = (w_esum >= c_xw'(E_max));

  always_comb begin
    w_pack = '0;  // zero input: all zeros, never negative zero
    if (!r_zero1) begin
      if (w_ovf) begin
        w_pack = {r_s1, c_e_sat, {F_bit{1'b1}}};
      end else begin
        w_pack = {r_s1, w_esum[E_bit-1:0], w_frac};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_mag0  <= '0;
      r_mag1  <= '0;
      r_p     <= '0;
      r_zero1 <= 1'b0;
      r_out   <= '0;
    end else if (w_adv) begin
      r_v0    <= in_valid;
      r_s0    <= w_s0;
      r_mag0  <= w_mag0;
      r_v1    <= r_v0;
      r_s1    <= r_s0;
      r_mag1  <= r_mag0;
      r_p     <= w_p;
      r_zero1 <= w_zero;
      r_v2    <= r_v1;
      r_out   <= w_pack;
    end
  end

endmodule
`default_nettype wire
